// File: rtl/p2m_echo_indication.sv
// Receive-side demarshaller for EchoIndication. It buffers 144-bit pipe words,
// decodes the head and calls heard, heard2 or heard3. Define P2M_ECHO_STATS_EN to build stat_ok/stat_bad.
module p2m_echo_indication #(
  parameter int DEPTH     = 2,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 pipe_enq__ENA,
  input  logic [143:0]         pipe_enq_v,
  output logic                 pipe_enq__RDY,
  output logic                 heard__ENA,
  output logic [31:0]          heard_v,
  input  logic                 heard__RDY,
  output logic                 heard2__ENA,
  output logic [15:0]          heard2_a,
  output logic [15:0]          heard2_b,
  input  logic                 heard2__RDY,
  output logic                 heard3__ENA,
  output logic [15:0]          heard3_a,
  output logic [15:0]          heard3_b,
  output logic [31:0]          heard3_c,
  output logic [31:0]          heard3_d,
  input  logic                 heard3__RDY,
  output logic                 err_drop,
  output logic [CNT_WIDTH-1:0] stat_ok,
  output logic [CNT_WIDTH-1:0] stat_bad
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // argc travels with the word but is never checked, so it is not stored
  logic unused_argc;
  assign unused_argc = ^pipe_enq_v[15:0];

  logic [127:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic          full;
  logic          head_valid;
  logic [127:0]  head;
  logic [15:0]   head_idx;
  logic [15:0]   head_len;
  logic [95:0]   head_pl;
  logic          good;
  logic          do_enq;
  logic          do_deq;
  logic          drop;
  logic          dispatch;

  assign full          = (count == FULL_CNT);
  assign head_valid    = (count != '0);
  assign pipe_enq__RDY = !full && !RST;
  assign do_enq        = pipe_enq__ENA && !full;

  assign head     = head_valid ? mem[rd_ptr] : '0;
  assign head_idx = head[127:112];
  assign head_len = head[111:96];
  assign head_pl  = head[95:0];
  assign good     = (head_idx <= 16'd2) && (head_len == 16'd5);

  always_comb begin
    heard__ENA  = 1'b0;
    heard2__ENA = 1'b0;
    heard3__ENA = 1'b0;
    if (head_valid && good) begin
      case (head_idx)
        16'd0:   heard__ENA  = heard__RDY;
        16'd1:   heard2__ENA = heard2__RDY;
        16'd2:   heard3__ENA = heard3__RDY;
        default: ;
      endcase
    end
  end

  assign dispatch = heard__ENA || heard2__ENA || heard3__ENA;
  assign drop     = head_valid && !good;
  assign do_deq   = dispatch || drop;

  // Argument fields are shared between methods; head is zero when empty.
  assign heard_v  = head_pl[95:64];
  assign heard2_a = head_pl[95:80];
  assign heard2_b = head_pl[79:64];
  assign heard3_a = head_pl[95:80];
  assign heard3_b = head_pl[79:64];
  assign heard3_c = head_pl[63:32];
  assign heard3_d = head_pl[31:0];

  always_ff @(posedge CLK) begin
    if (do_enq) begin
      mem[wr_ptr] <= pipe_enq_v[143:16];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      err_drop <= 1'b0;
    end else begin
      if (do_enq) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_deq) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (do_enq && !do_deq) begin
        count <= count + CW'(1);
      end else if (!do_enq && do_deq) begin
        count <= count - CW'(1);
      end
      if (drop) begin
        err_drop <= 1'b1;
      end
    end
  end

`ifdef P2M_ECHO_STATS_EN
  logic [CNT_WIDTH-1:0] ok_q;
  logic [CNT_WIDTH-1:0] bad_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ok_q  <= '0;
      bad_q <= '0;
    end else begin
      if (dispatch && (ok_q != '1)) begin
        ok_q <= ok_q + CNT_WIDTH'(1);
      end
      if (drop && (bad_q != '1)) begin
        bad_q <= bad_q + CNT_WIDTH'(1);
      end
    end
  end

  assign stat_ok  = ok_q;
  assign stat_bad = bad_q;
`else
  assign stat_ok  = '0;
  assign stat_bad = '0;
`endif

endmodule
